// File: rtl/mem_access_unit_pkg.sv
// Shared load/store definitions for the MEM stage: funct3 encodings, LSU
// FSM states, the data-memory request payload and the access helpers.
package mem_access_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2
  } lsu_state_e;

  // Data-memory request payload (valid is carried separately)
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dmem_req_t;

  // Size/alignment legality; read and write together is never legal.
  function automatic logic access_legal(input logic       rd,
                                        input logic       wr,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (rd ^ wr) begin
      case (f3)
        F3_LB:   ok = 1'b1;
        F3_LH:   ok = ~off[0];
        F3_LW:   ok = (off == 2'b00);
        F3_LBU:  ok = rd;
        F3_LHU:  ok = rd & ~off[0];
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Byte enables for the access size at the given byte offset.
  function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [BE_W-1:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/half lane of the read word
// and sign- or zero-extends it.
//   i_rdata  : raw read word from data memory
//   i_offset : byte offset addr[1:0] of the access
//   i_funct3 : load size/sign encoding
//   o_data   : formatted load data (0 for non-load encodings)
module lsu_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Lane select
  always_comb begin
    byte_c = i_rdata[7:0];
    case (i_offset)
      2'd0:    byte_c = i_rdata[7:0];
      2'd1:    byte_c = i_rdata[15:8];
      2'd2:    byte_c = i_rdata[23:16];
      default: byte_c = i_rdata[31:24];
    endcase
    half_c = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extension
  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:   o_data = {{24{byte_c[7]}}, byte_c};
      F3_LH:   o_data = {{16{half_c[15]}}, half_c};
      F3_LW:   o_data = i_rdata;
      F3_LBU:  o_data = {24'd0, byte_c};
      F3_LHU:  o_data = {16'd0, half_c};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into a single
// outstanding req/gnt/rvalid data-memory transaction, stalls the pipeline
// while it is outstanding and returns formatted load data.
//   i_clk, i_arst_n            : clock, async active-low reset
//   i_valid/i_mem_read/i_mem_write/i_funct3/i_addr/i_store_data : EX/MEM controls
//   o_load_data                : formatted load data to MEM/WB
//   o_stall                    : pipeline hold while the access is in flight
//   o_access_err               : one-cycle misaligned/illegal access flag
//   o_dmem_*, i_dmem_*         : data-memory request / response bus
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned N = XLEN
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          i_valid,
  input  logic          i_mem_read,
  input  logic          i_mem_write,
  input  logic [2:0]    i_funct3,
  input  logic [N-1:0]  i_addr,
  input  logic [N-1:0]  i_store_data,
  output logic [N-1:0]  o_load_data,
  output logic          o_stall,
  output logic          o_access_err,
  output logic          o_dmem_req,
  output logic          o_dmem_we,
  output logic [N-1:0]  o_dmem_addr,
  output logic [3:0]    o_dmem_be,
  output logic [N-1:0]  o_dmem_wdata,
  input  logic          i_dmem_gnt,
  input  logic          i_dmem_rvalid,
  input  logic [N-1:0]  i_dmem_rdata
);

  lsu_state_e      state_q, state_d;
  dmem_req_t       req_q;
  logic [1:0]      off_q;
  logic [2:0]      funct3_q;
  logic [N-1:0]    load_data_q;

  logic            access_c;
  logic            legal_c;
  dmem_req_t       req_in_c;
  dmem_req_t       bus_c;
  logic            req_c;
  logic            stall_c;
  logic            err_c;
  logic            capture_c;
  logic            load_upd_c;
  logic [N-1:0]    aligned_c;
  logic [N-1:0]    load_c;

  assign access_c = i_valid & (i_mem_read | i_mem_write);
  assign legal_c  = access_legal(i_mem_read, i_mem_write, i_funct3, i_addr[1:0]);

  // Request payload built straight from EX/MEM; stores replicate into lanes
  always_comb begin
    req_in_c.we    = i_mem_write;
    req_in_c.addr  = {i_addr[N-1:2], 2'b00};
    req_in_c.be    = lane_be(i_funct3, i_addr[1:0]);
    req_in_c.wdata = '0;
    if (i_mem_write) begin
      case (i_funct3[1:0])
        2'b00:   req_in_c.wdata = {4{i_store_data[7:0]}};
        2'b01:   req_in_c.wdata = {2{i_store_data[15:0]}};
        default: req_in_c.wdata = i_store_data;
      endcase
    end
  end

  lsu_load_align u_load_align (
    .i_rdata  (i_dmem_rdata),
    .i_offset (off_q),
    .i_funct3 (funct3_q),
    .o_data   (aligned_c)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state and bus/pipeline controls
  always_comb begin
    state_d    = state_q;
    req_c      = 1'b0;
    bus_c      = '0;
    stall_c    = 1'b0;
    err_c      = 1'b0;
    capture_c  = 1'b0;
    load_upd_c = 1'b0;
    load_c     = load_data_q;
    case (state_q)
      IDLE: begin
        if (access_c) begin
          if (legal_c) begin
            req_c     = 1'b1;
            bus_c     = req_in_c;
            capture_c = 1'b1;
            if (i_dmem_gnt) begin
              // A granted store completes here; a load waits for its data
              state_d = req_in_c.we ? IDLE : WAIT_RESP;
              stall_c = ~req_in_c.we;
            end else begin
              state_d = WAIT_GNT;
              stall_c = 1'b1;
            end
          end else begin
            err_c  = 1'b1;
            load_c = '0;
          end
        end
      end
      WAIT_GNT: begin
        req_c = 1'b1;
        bus_c = req_q;
        if (i_dmem_gnt) begin
          state_d = req_q.we ? IDLE : WAIT_RESP;
          stall_c = ~req_q.we;
        end else begin
          stall_c = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (i_dmem_rvalid) begin
          load_c     = aligned_c;
          load_upd_c = 1'b1;
          state_d    = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched request and load-data copy
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      req_q       <= '0;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      load_data_q <= '0;
    end else begin
      if (capture_c) begin
        req_q    <= req_in_c;
        off_q    <= i_addr[1:0];
        funct3_q <= i_funct3;
      end
      if (load_upd_c)  load_data_q <= aligned_c;
      else if (err_c)  load_data_q <= '0;
    end
  end

  // Bus and pipeline outputs are forced quiet while reset is asserted
  assign o_dmem_req   = req_c & i_arst_n;
  assign o_dmem_we    = bus_c.we & i_arst_n;
  assign o_dmem_addr  = i_arst_n ? bus_c.addr  : '0;
  assign o_dmem_be    = i_arst_n ? bus_c.be    : '0;
  assign o_dmem_wdata = i_arst_n ? bus_c.wdata : '0;
  assign o_stall      = stall_c & i_arst_n;
  assign o_access_err = err_c & i_arst_n;
  assign o_load_data  = load_c;

endmodule
